// File: rtl/vram_arbiter.sv
// Shares one single-port, 1-cycle-latency VRAM between the VGA pixel fetcher and the CPU.
// VGA wins conflicts; a starvation counter forces a CPU slot and defers that cycle's VGA read.
module vram_arbiter #(
  parameter int AW           = 14,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int SW           = 3
) (
  input  logic          CLOCK_50,
  input  logic          KEY0,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_rvalid,
  output logic [DW-1:0] vga_rdata,
  output logic          vga_late,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE     = 2'd0,
    OWN_VGA      = 2'd1,
    OWN_VGA_LATE = 2'd2,
    OWN_CPU      = 2'd3
  } owner_e;

  owner_e        owner_q, owner_d;
  logic          pend_v_q, pend_v_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          cpu_busy_q, cpu_busy_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [DW-1:0] vga_rdata_q, vga_rdata_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;

  logic cpu_elig;
  logic starved;
  logic cpu_grant;
  logic vga_issue;

  assign cpu_elig = cpu_req & ~cpu_busy_q;
  assign starved  = (starve_q == SW'(STARVE_LIMIT));

  // Issue mux. Gated by KEY0 so the RAM port goes quiet the moment reset asserts.
  always_comb begin
    owner_d     = OWN_NONE;
    pend_v_d    = 1'b0;
    pend_addr_d = pend_addr_q;
    starve_d    = starve_q;
    cpu_busy_d  = 1'b0;
    last_addr_d = last_addr_q;
    cpu_grant   = 1'b0;
    vga_issue   = 1'b0;
    ram_addr    = last_addr_q;
    ram_we      = 1'b0;
    ram_wdata   = '0;
    if (KEY0) begin
      if (pend_v_q) begin
        ram_addr = pend_addr_q;
        owner_d  = OWN_VGA_LATE;
      end else if (cpu_elig && starved) begin
        cpu_grant = 1'b1;
      end else if (vga_req) begin
        ram_addr  = vga_addr;
        owner_d   = OWN_VGA;
        vga_issue = 1'b1;
      end else if (cpu_elig) begin
        cpu_grant = 1'b1;
      end

      if (cpu_grant) begin
        ram_addr   = cpu_addr;
        ram_we     = cpu_we;
        ram_wdata  = cpu_we ? cpu_wdata : '0;
        owner_d    = OWN_CPU;
        cpu_busy_d = 1'b1;
      end
      last_addr_d = ram_addr;

      // A VGA request that did not win this cycle is parked; pend never overflows
      // because the forced CPU slot ranks below a pending drain.
      pend_v_d = vga_req & ~vga_issue;
      if (pend_v_d) pend_addr_d = vga_addr;

      if (cpu_grant || !cpu_elig) starve_d = '0;
      else if (!starved)          starve_d = starve_q + SW'(1);
    end
  end

  assign vga_rvalid = (owner_q == OWN_VGA) || (owner_q == OWN_VGA_LATE);
  assign vga_late   = (owner_q == OWN_VGA_LATE);
  assign cpu_ack    = (owner_q == OWN_CPU);

  // Read data is shown live in the response cycle and held afterwards.
  always_comb begin
    vga_rdata_d = vga_rvalid ? ram_rdata : vga_rdata_q;
    cpu_rdata_d = cpu_ack    ? ram_rdata : cpu_rdata_q;
  end

  assign vga_rdata = vga_rdata_d;
  assign cpu_rdata = cpu_rdata_d;

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      owner_q     <= OWN_NONE;
      pend_v_q    <= 1'b0;
      pend_addr_q <= '0;
      starve_q    <= '0;
      cpu_busy_q  <= 1'b0;
      last_addr_q <= '0;
      vga_rdata_q <= '0;
      cpu_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      pend_v_q    <= pend_v_d;
      pend_addr_q <= pend_addr_d;
      starve_q    <= starve_d;
      cpu_busy_q  <= cpu_busy_d;
      last_addr_q <= last_addr_d;
      vga_rdata_q <= vga_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed cycle tables, a reset-abort sequence, and
// randomized traffic scored against a RAM model plus a request-level reference.
module tb_vram_arbiter;
  localparam int AW  = 14;
  localparam int DW  = 16;
  localparam int LIM = 4;
  localparam int NRND = 10000;

  logic          CLOCK_50 = 1'b0;
  logic          KEY0 = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_rvalid, vga_late, cpu_ack, ram_we;
  logic [DW-1:0] vga_rdata, cpu_rdata, ram_wdata;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_rdata;

  vram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM), .SW(3)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_rvalid(vga_rvalid),
    .vga_rdata(vga_rdata), .vga_late(vga_late),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic logic [DW-1:0] ini(logic [AW-1:0] a);
    return {2'b10, a} ^ 16'h5A5A;
  endfunction

  // RAM: stores value XOR a per-address pattern, so untouched words read as ini(a).
  bit [DW-1:0] ram_mem [0:(1<<AW)-1];
  always @(posedge CLOCK_50) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata ^ ini(ram_addr);
    ram_rdata <= ram_mem[ram_addr] ^ ini(ram_addr);
  end

  // Reference memory at request level: updated only when the bench sees a write acked.
  logic [DW-1:0] ref_m [int];
  function automatic logic [DW-1:0] ref_rd(int a);
    if (ref_m.exists(a)) return ref_m[a];
    return ini(AW'(a));
  endfunction

  logic trk;
  always @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) trk <= 1'b0;
    else begin
      assert (!(trk && !cpu_req && !cpu_ack)) else $error("cpu_req dropped before cpu_ack");
      if (cpu_ack)      trk <= 1'b0;
      else if (cpu_req) trk <= 1'b1;
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_le(string nm, int act, int lim);
    n_chk++;
    if (act <= lim) n_pass++;
    else $display("FAIL %s: got %0d, expected <= %0d", nm, act, lim);
  endtask

  typedef struct {
    string nm;
    bit vr; int va; bit cr; bit cw; int ca; int cd;
    bit ewe; int ea; bit erv; bit elt; int eva; bit eack; bit erd; int erdv;
  } vec_t;

  function automatic vec_t mk(string nm, bit vr, int va, bit cr, bit cw, int ca, int cd,
                              bit ewe, int ea, bit erv, bit elt, int eva, bit eack, bit erd, int erdv);
    vec_t v;
    v.nm = nm; v.vr = vr; v.va = va; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.ewe = ewe; v.ea = ea; v.erv = erv; v.elt = elt; v.eva = eva;
    v.eack = eack; v.erd = erd; v.erdv = erdv;
    return v;
  endfunction

  typedef struct { logic [AW-1:0] a; int c; } vq_t;

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    vq_t  vq[$];
    vq_t  e;
    bit   c_out, c_we;
    int   c_start, c_addr, c_dly, vrun, vgap, lat;
    logic [DW-1:0] c_wd;

    // reset state
    #2;
    chk("rst_vga_rvalid", vga_rvalid, 0);
    chk("rst_vga_late",   vga_late,   0);
    chk("rst_cpu_ack",    cpu_ack,    0);
    chk("rst_ram_we",     ram_we,     0);
    chk("rst_ram_addr",   ram_addr,   0);
    chk("rst_ram_wdata",  ram_wdata,  0);
    chk("rst_vga_rdata",  vga_rdata,  0);
    chk("rst_cpu_rdata",  cpu_rdata,  0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    KEY0 = 1'b1;

    // T1: write then read back, no VGA traffic
    tv.push_back(mk("t1", 0,0,     1,1,'h10,'hBEEF, 1,'h10,  0,0,0,      0,0,0));
    tv.push_back(mk("t1", 0,0,     0,0,0,0,         0,'h10,  0,0,0,      1,0,0));
    tv.push_back(mk("t1", 0,0,     1,0,'h10,0,      0,'h10,  0,0,0,      0,0,0));
    tv.push_back(mk("t1", 0,0,     0,0,0,0,         0,'h10,  0,0,0,      1,1,'hBEEF));
    tv.push_back(mk("t1", 0,0,     0,0,0,0,         0,'h10,  0,0,0,      0,0,0));
    // T2: VGA every cycle, CPU write held; forced slot on the 5th cycle
    tv.push_back(mk("t2", 1,'h100, 1,1,'h20,'h1234, 0,'h100, 0,0,0,      0,0,0));
    tv.push_back(mk("t2", 1,'h101, 1,1,'h20,'h1234, 0,'h101, 1,0,'h100,  0,0,0));
    tv.push_back(mk("t2", 1,'h102, 1,1,'h20,'h1234, 0,'h102, 1,0,'h101,  0,0,0));
    tv.push_back(mk("t2", 1,'h103, 1,1,'h20,'h1234, 0,'h103, 1,0,'h102,  0,0,0));
    tv.push_back(mk("t2", 1,'h104, 1,1,'h20,'h1234, 1,'h20,  1,0,'h103,  0,0,0));
    tv.push_back(mk("t2", 1,'h105, 0,0,0,0,         0,'h104, 0,0,0,      1,0,0));
    tv.push_back(mk("t2", 1,'h106, 0,0,0,0,         0,'h105, 1,1,'h104,  0,0,0));
    tv.push_back(mk("t2", 0,0,     0,0,0,0,         0,'h106, 1,1,'h105,  0,0,0));
    tv.push_back(mk("t2", 0,0,     0,0,0,0,         0,'h106, 1,1,'h106,  0,0,0));
    tv.push_back(mk("t2", 0,0,     0,0,0,0,         0,'h106, 0,0,0,      0,0,0));
    // T3: simultaneous first request, VGA goes first, no late flag
    tv.push_back(mk("t3", 1,'h200, 1,0,'h10,0,      0,'h200, 0,0,0,      0,0,0));
    tv.push_back(mk("t3", 0,0,     1,0,'h10,0,      0,'h10,  1,0,'h200,  0,0,0));
    tv.push_back(mk("t3", 0,0,     0,0,0,0,         0,'h10,  0,0,0,      1,1,'hBEEF));
    tv.push_back(mk("t3", 0,0,     0,0,0,0,         0,'h10,  0,0,0,      0,0,0));
    // T4: cpu_req held through ack into the next access; no reissue in the ack cycle
    tv.push_back(mk("t4", 0,0,     1,1,'h30,'h1111, 1,'h30,  0,0,0,      0,0,0));
    tv.push_back(mk("t4", 0,0,     1,1,'h31,'h2222, 0,'h30,  0,0,0,      1,0,0));
    tv.push_back(mk("t4", 0,0,     1,1,'h31,'h2222, 1,'h31,  0,0,0,      0,0,0));
    tv.push_back(mk("t4", 0,0,     0,0,0,0,         0,'h31,  0,0,0,      1,0,0));
    tv.push_back(mk("t4", 0,0,     0,0,0,0,         0,'h31,  0,0,0,      0,0,0));
    tv.push_back(mk("t4", 0,0,     1,0,'h30,0,      0,'h30,  0,0,0,      0,0,0));
    tv.push_back(mk("t4", 0,0,     1,0,'h31,0,      0,'h30,  0,0,0,      1,1,'h1111));
    tv.push_back(mk("t4", 0,0,     1,0,'h31,0,      0,'h31,  0,0,0,      0,0,0));
    tv.push_back(mk("t4", 0,0,     0,0,0,0,         0,'h31,  0,0,0,      1,1,'h2222));
    tv.push_back(mk("t4", 0,0,     0,0,0,0,         0,'h31,  0,0,0,      0,0,0));

    foreach (tv[i]) begin
      vga_req = tv[i].vr; vga_addr = AW'(tv[i].va);
      cpu_req = tv[i].cr; cpu_we = tv[i].cw;
      cpu_addr = AW'(tv[i].ca); cpu_wdata = DW'(tv[i].cd);
      #1;
      chk($sformatf("%s[%0d].ram_we", tv[i].nm, i), ram_we, tv[i].ewe);
      chk($sformatf("%s[%0d].ram_addr", tv[i].nm, i), ram_addr, tv[i].ea);
      if (tv[i].ewe) chk($sformatf("%s[%0d].ram_wdata", tv[i].nm, i), ram_wdata, tv[i].cd);
      chk($sformatf("%s[%0d].vga_rvalid", tv[i].nm, i), vga_rvalid, tv[i].erv);
      chk($sformatf("%s[%0d].vga_late", tv[i].nm, i), vga_late, tv[i].elt);
      if (tv[i].erv) chk($sformatf("%s[%0d].vga_rdata", tv[i].nm, i), vga_rdata, ini(AW'(tv[i].eva)));
      chk($sformatf("%s[%0d].cpu_ack", tv[i].nm, i), cpu_ack, tv[i].eack);
      if (tv[i].erd) chk($sformatf("%s[%0d].cpu_rdata", tv[i].nm, i), cpu_rdata, tv[i].erdv);
      @(negedge CLOCK_50);
    end

    // T5: reset mid-transaction, in the forced CPU read cycle that also parks a VGA read
    for (int i = 0; i < 5; i++) begin
      vga_req = 1'b1; vga_addr = AW'(32'h110 + i);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(32'h10);
      if (i < 4) @(negedge CLOCK_50);
    end
    #1;
    chk("t5_forced_addr", ram_addr, 'h10);
    #2;
    KEY0 = 1'b0;
    #1;
    chk("t5_rst_vga_rvalid", vga_rvalid, 0);
    chk("t5_rst_vga_late",   vga_late,   0);
    chk("t5_rst_cpu_ack",    cpu_ack,    0);
    chk("t5_rst_ram_we",     ram_we,     0);
    chk("t5_rst_ram_addr",   ram_addr,   0);
    chk("t5_rst_ram_wdata",  ram_wdata,  0);
    chk("t5_rst_vga_rdata",  vga_rdata,  0);
    chk("t5_rst_cpu_rdata",  cpu_rdata,  0);
    vga_req = 1'b0; cpu_req = 1'b0;
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5_post[%0d].cpu_ack", i), cpu_ack, 0);
      chk($sformatf("t5_post[%0d].vga_rvalid", i), vga_rvalid, 0);
      @(negedge CLOCK_50);
    end
    // starve counter starts from zero: forced CPU slot lands exactly on the 5th cycle
    for (int i = 0; i < 6; i++) begin
      vga_req = (i < 5); vga_addr = AW'(32'h120 + i);
      cpu_req = (i < 5); cpu_we = 1'b1; cpu_addr = AW'(32'h21); cpu_wdata = 16'h5555;
      #1;
      if (i < 5) chk($sformatf("t5_starve[%0d].ram_we", i), ram_we, (i == 4));
      else       chk("t5_starve.cpu_ack", cpu_ack, 1);
      @(negedge CLOCK_50);
    end
    repeat (3) @(negedge CLOCK_50);

    // T6: random traffic. VGA in bursts of 1..8 separated by >=2 idle cycles.
    c_out = 0; c_we = 0; c_start = 0; c_addr = 0; c_wd = '0; c_dly = 0; vrun = 0; vgap = 0;
    for (int k = 0; k < NRND + 20; k++) begin
      if (cpu_ack) begin
        if (!c_out) chk("rnd_cpu_ack_spurious", cpu_ack, 0);
        else begin
          if (!c_we) chk($sformatf("rnd_cpu_rdata@%0h", c_addr), cpu_rdata, ref_rd(c_addr));
          else ref_m[c_addr] = c_wd;
          chk_le("rnd_cpu_wait", k - c_start, LIM + 2);
          c_out = 0;
        end
      end else if (c_out && (k - c_start) > 40) begin
        chk("rnd_cpu_timeout", cpu_ack, 1);
        c_out = 0;
      end

      if (vga_rvalid) begin
        if (vq.size() == 0) chk("rnd_vga_spurious", vga_rvalid, 0);
        else begin
          e = vq.pop_front();
          lat = k - e.c;
          chk_le("rnd_vga_latency", lat, 2);
          chk("rnd_vga_late_flag", vga_late, (lat == 2));
          chk($sformatf("rnd_vga_rdata@%0h", e.a), vga_rdata, ref_rd(e.a));
        end
      end
      while (vq.size() > 0 && (k - vq[0].c) >= 2) begin
        chk("rnd_vga_lost", 0, 1);
        void'(vq.pop_front());
      end

      if (k < NRND) begin
        if (vrun == 0 && vgap == 0) vrun = $urandom_range(1, 8);
        if (vrun > 0) begin
          vga_req = 1'b1;
          vga_addr = AW'($urandom_range(64, 127));
          e.a = vga_addr; e.c = k;
          vq.push_back(e);
          vrun--;
          if (vrun == 0) vgap = $urandom_range(2, 6);
        end else begin
          vga_req = 1'b0;
          vgap--;
        end
        if (!c_out) begin
          if (c_dly == 0) begin
            c_out = 1; c_start = k;
            c_we = 1'($urandom_range(0, 1));
            c_addr = $urandom_range(64, 127);
            c_wd = DW'($urandom);
            cpu_req = 1'b1; cpu_we = c_we; cpu_addr = AW'(c_addr); cpu_wdata = c_wd;
            c_dly = $urandom_range(0, 3);
          end else begin
            cpu_req = 1'b0;
            c_dly--;
          end
        end
      end else begin
        vga_req = 1'b0;
        if (!c_out) cpu_req = 1'b0;
      end
      @(negedge CLOCK_50);
    end
    chk("rnd_vga_drained", vq.size(), 0);
    chk("rnd_cpu_drained", c_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
